// File: rtl/issue_dispatch_ctrl.sv
// Issue-queue dispatch controller.
// Accepts up to four micro-ops per cycle from rename, acknowledges grants to the two
// execution ports, tracks queue occupancy and sequences a branch kill through a
// one-cycle KILL window followed by a one-cycle occupancy resync from the queue.
module issue_dispatch_ctrl #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned WIDTH_BRM = 3,
  parameter int unsigned WIDTH_CNT = $clog2(SIZE + 1),
  parameter int unsigned ALMOST    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [3:0]           i_valid,
  input  logic                 i_stall,
  output logic                 o_ready,
  output logic [3:0]           o_lane_en,
  output logic                 o_en,
  input  logic [1:0]           i_issue,
  input  logic [1:0]           i_exec_ready,
  output logic [1:0]           o_issue_ack,
  input  logic [WIDTH_BRM:0]   i_BrKill,
  input  logic [WIDTH_CNT-1:0] i_occ,
  output logic [WIDTH_CNT-1:0] o_count,
  output logic                 o_almost_full,
  output logic                 o_empty,
  output logic                 o_err
);

  // One extra bit so occupancy arithmetic can see overflow and underflow.
  localparam int unsigned CW = WIDTH_CNT + 1;

  localparam logic [CW-1:0] SizeW     = CW'(SIZE);
  localparam logic [CW-1:0] BundleW   = CW'(4);
  localparam logic [CW-1:0] AlmostW   = CW'(ALMOST);
  localparam logic          AlmostRst = (SIZE < ALMOST);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StKill   = 2'd1,
    StResync = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH_CNT-1:0] count_q, count_d;
  logic                 err_q, err_d;
  logic                 almost_full_q, almost_full_d;
  logic                 empty_q, empty_d;

  logic                 kill_en;
  logic [CW-1:0]        free_q;
  logic [CW-1:0]        free_d;
  logic                 room;
  logic                 accept;
  logic [CW-1:0]        add_sum;
  logic [CW-1:0]        diff_sum;
  logic [2:0]           pop_lane;
  logic [1:0]           pop_ack;

  // Branch mask bits are applied by the queue slots themselves, not here.
  logic                 unused_brmask;
  assign unused_brmask = ^i_BrKill[WIDTH_BRM-1:0];

  assign kill_en = i_BrKill[WIDTH_BRM];

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    popcnt2 = 2'(v[0]) + 2'(v[1]);
  endfunction

  // Free slots and the conservative "a full bundle fits" check.
  assign free_q = SizeW - {1'b0, count_q};
  assign room   = (free_q >= BundleW);

  // State register and registered status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StRun;
      count_q       <= '0;
      err_q         <= 1'b0;
      almost_full_q <= AlmostRst;
      empty_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      err_q         <= err_d;
      almost_full_q <= almost_full_d;
      empty_q       <= empty_d;
    end
  end

  // Next-state: any kill restarts the KILL/RESYNC sequence from any state.
  always_comb begin
    state_d = state_q;
    if (kill_en) begin
      state_d = StKill;
    end else begin
      unique case (state_q)
        StRun:    state_d = StRun;
        StKill:   state_d = StResync;
        StResync: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  // Outputs: dispatch/issue handshakes only in RUN; KILL pulses the queue enable.
  always_comb begin
    o_ready     = 1'b0;
    o_lane_en   = 4'b0000;
    o_issue_ack = 2'b00;
    o_en        = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StRun: begin
        o_ready     = ~i_stall & room;
        accept      = (|i_valid) & o_ready;
        o_lane_en   = accept ? i_valid : 4'b0000;
        o_issue_ack = i_issue & i_exec_ready;
        o_en        = accept | (|o_issue_ack);
      end
      StKill: begin
        o_en = 1'b1;
      end
      StResync: begin
        o_en = 1'b0;
      end
      default: begin
        o_en = 1'b0;
      end
    endcase
  end

  assign pop_lane = popcnt4(o_lane_en);
  assign pop_ack  = popcnt2(o_issue_ack);
  assign add_sum  = {1'b0, count_q} + CW'(pop_lane);
  assign diff_sum = add_sum - CW'(pop_ack);

  // Occupancy update with clamping; any clamp or empty-queue issue is sticky in err.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case (state_q)
      StRun: begin
        if ((|o_issue_ack) && (count_q == '0)) begin
          err_d = 1'b1;
        end
        if (add_sum < CW'(pop_ack)) begin
          count_d = '0;
          err_d   = 1'b1;
        end else if (diff_sum > SizeW) begin
          count_d = WIDTH_CNT'(SIZE);
          err_d   = 1'b1;
        end else begin
          count_d = diff_sum[WIDTH_CNT-1:0];
        end
      end
      StKill: begin
        count_d = count_q;
      end
      StResync: begin
        // A kill landing here re-enters KILL; the queue is not yet settled, so hold.
        if (!kill_en) begin
          if ({1'b0, i_occ} > SizeW) begin
            count_d = WIDTH_CNT'(SIZE);
            err_d   = 1'b1;
          end else begin
            count_d = i_occ;
          end
        end
      end
      default: begin
        count_d = '0;
      end
    endcase
  end

  // Status flags are registered from the next occupancy so they track o_count.
  assign free_d = SizeW - {1'b0, count_d};

  always_comb begin
    almost_full_d = (free_d < AlmostW);
    empty_d       = (count_d == '0);
  end

  assign o_count       = count_q;
  assign o_almost_full = almost_full_q;
  assign o_empty       = empty_q;
  assign o_err         = err_q;

endmodule
